// File: rtl/rasteriza_caixa_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : raster_pkg
//  Desc    : Shared constants, scan state encoding and unsigned min/max
//            helpers for the triangle bounding-box rasteriser.
//  Rev     : 1.0  initial release
// ============================================================================
package raster_pkg;

   localparam int W_DEF    = 12;
   localparam int LARG_DEF = 640;
   localparam int ALT_DEF  = 480;

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SCAN = 2'd2, FIM = 2'd3} estado_e;

   // Operands are zero-extended by callers, so a 32-bit compare stays unsigned.
   function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
      logic [31:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [31:0] max3(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
      logic [31:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rasteriza_caixa_if.sv
`default_nettype none
// ============================================================================
//  Module  : rasteriza_caixa_if
//  Desc    : Triangle-in / point-out handshake bundle of the rasteriser.
//  Rev     : 1.0  initial release
// ============================================================================
interface rasteriza_caixa_if #(parameter int W = 12);

   logic         tri_valid;
   logic         tri_ready;
   logic [W-1:0] t1x, t1y, t2x, t2y, t3x, t3y;
   logic         pt_valid;
   logic         pt_ready;
   logic [W-1:0] ptx, pty;
   logic [W-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
   logic         pt_last;
   logic         fim;
   logic         ocupado;

   // master: the rasteriser itself
   modport master (
      input  tri_valid, t1x, t1y, t2x, t2y, t3x, t3y, pt_ready,
      output tri_ready, pt_valid, ptx, pty, p1x, p1y, p2x, p2y, p3x, p3y,
             pt_last, fim, ocupado
   );

   // slave: triangle source plus point consumer
   modport slave (
      output tri_valid, t1x, t1y, t2x, t2y, t3x, t3y, pt_ready,
      input  tri_ready, pt_valid, ptx, pty, p1x, p1y, p2x, p2y, p3x, p3y,
             pt_last, fim, ocupado
   );

endinterface
`default_nettype wire

// File: rtl/rasteriza_caixa_min_max3.sv
`default_nettype none
// ============================================================================
//  Module  : min_max3
//  Desc    : Combinational unsigned minimum and maximum of three values.
//  Rev     : 1.0  initial release
// ============================================================================
module min_max3
   import raster_pkg::*;
#(
   parameter int W = 12
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] mn,
   output logic [W-1:0] mx
);

   assign mn = W'(min3(32'(a), 32'(b), 32'(c)));
   assign mx = W'(max3(32'(a), 32'(b), 32'(c)));

endmodule
`default_nettype wire

// File: rtl/rasteriza_caixa.sv
`default_nettype none
// ============================================================================
//  Module  : rasteriza_caixa
//  Desc    : Captures a triangle, derives its screen-clipped bounding box and
//            walks the box row-major, one candidate point per handshake.
//  Rev     : 1.0  initial release
// ============================================================================
module rasteriza_caixa
   import raster_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int LARG = LARG_DEF,
   parameter int ALT  = ALT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   rasteriza_caixa_if.master  bus
);

   localparam logic [1:0]   c_st_idle  = 2'(IDLE);
   localparam logic [1:0]   c_st_setup = 2'(SETUP);
   localparam logic [1:0]   c_st_scan  = 2'(SCAN);
   localparam logic [1:0]   c_st_fim   = 2'(FIM);
   localparam logic [W-1:0] c_xlim     = W'(LARG - 1);
   localparam logic [W-1:0] c_ylim     = W'(ALT - 1);

   logic [1:0]   r_estado;
   logic [W-1:0] r_p1x, r_p1y, r_p2x, r_p2y, r_p3x, r_p3y;
   logic [W-1:0] r_xmin, r_xmax, r_ymax;
   logic [W-1:0] r_ptx, r_pty;

   logic [W-1:0] w_xmn, w_xmx, w_ymn, w_ymx;
   logic         w_vazio, w_xfim, w_yfim;

   min_max3 #(.W(W)) u_mm_x (.a(r_p1x), .b(r_p2x), .c(r_p3x), .mn(w_xmn), .mx(w_xmx));
   min_max3 #(.W(W)) u_mm_y (.a(r_p1y), .b(r_p2y), .c(r_p3y), .mn(w_ymn), .mx(w_ymx));

   assign w_vazio = (w_xmn > c_xlim) || (w_ymn > c_ylim);
   assign w_xfim  = (r_ptx == r_xmax);
   assign w_yfim  = (r_pty == r_ymax);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado <= c_st_idle;
         r_p1x <= '0; r_p1y <= '0; r_p2x <= '0; r_p2y <= '0; r_p3x <= '0; r_p3y <= '0;
         r_xmin <= '0; r_xmax <= '0; r_ymax <= '0;
         r_ptx  <= '0; r_pty  <= '0;
      end else begin
         case (r_estado)
            c_st_idle: begin
               if (bus.tri_valid) begin
                  r_p1x <= bus.t1x; r_p1y <= bus.t1y;
                  r_p2x <= bus.t2x; r_p2y <= bus.t2y;
                  r_p3x <= bus.t3x; r_p3y <= bus.t3y;
                  r_estado <= c_st_setup;
               end
            end
            c_st_setup: begin
               r_xmin   <= w_xmn;
               r_xmax   <= (w_xmx > c_xlim) ? c_xlim : w_xmx;
               r_ymax   <= (w_ymx > c_ylim) ? c_ylim : w_ymx;
               r_ptx    <= w_xmn;
               r_pty    <= w_ymn;
               r_estado <= w_vazio ? c_st_fim : c_st_scan;
            end
            c_st_scan: begin
               if (bus.pt_ready) begin
                  if (!w_xfim) begin
                     r_ptx <= r_ptx + 1'b1;
                  end else begin
                     r_ptx <= r_xmin;
                     // pty is left at ymax on exit so the counter never wraps
                     if (w_yfim) r_estado <= c_st_fim;
                     else        r_pty    <= r_pty + 1'b1;
                  end
               end
            end
            default: r_estado <= c_st_idle;
         endcase
      end
   end

   assign bus.tri_ready = (r_estado == c_st_idle);
   assign bus.ocupado   = (r_estado != c_st_idle);
   assign bus.pt_valid  = (r_estado == c_st_scan);
   assign bus.fim       = (r_estado == c_st_fim);
   assign bus.pt_last   = (r_estado == c_st_scan) && w_xfim && w_yfim;
   assign bus.ptx       = r_ptx;
   assign bus.pty       = r_pty;
   assign bus.p1x = r_p1x; assign bus.p1y = r_p1y;
   assign bus.p2x = r_p2x; assign bus.p2y = r_p2y;
   assign bus.p3x = r_p3x; assign bus.p3y = r_p3y;

endmodule
`default_nettype wire

// File: tb/tb_rasteriza_caixa.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rasteriza_caixa
//  Desc    : Directed self-checking bench for the bounding-box rasteriser.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_rasteriza_caixa;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   rasteriza_caixa_if #(.W(12)) bus ();

   rasteriza_caixa #(.W(12), .LARG(640), .ALT(480)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Offers a triangle in IDLE; returns in cycle 2 after acceptance.
   task automatic send_tri(input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3);
      bus.t1x = 12'(x1); bus.t1y = 12'(y1);
      bus.t2x = 12'(x2); bus.t2y = 12'(y2);
      bus.t3x = 12'(x3); bus.t3y = 12'(y3);
      bus.tri_valid = 1'b1;
      chk("tri_ready_c0", bus.tri_ready, 1);
      tick();
      bus.t1x = '0; bus.t1y = '0; bus.t2x = '0; bus.t2y = '0; bus.t3x = '0; bus.t3y = '0;
      chk("tri_ready_c1", bus.tri_ready, 0);
      chk("ocupado_c1",   bus.ocupado,   1);
      chk("pt_valid_c1",  bus.pt_valid,  0);
      chk("fim_c1",       bus.fim,       0);
      tick();
      chk("p1x", bus.p1x, x1); chk("p1y", bus.p1y, y1);
      chk("p2x", bus.p2x, x2); chk("p2y", bus.p2y, y2);
      chk("p3x", bus.p3x, x3); chk("p3y", bus.p3y, y3);
      bus.tri_valid = 1'b0;
   endtask

   // Walks the expected box; mode 0 = pt_ready always 1, mode 1 = 1-0-0 pattern.
   task automatic scan(input int xmn, input int xmx, input int ymn, input int ymx,
                       input int mode);
      int  x = xmn;
      int  y = ymn;
      int  cyc = 0;
      bit  done = 0;
      bit  pr;
      while (!done) begin
         pr = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         bus.pt_ready = pr;
         chk("pt_valid", bus.pt_valid, 1);
         chk("ptx",      bus.ptx,      x);
         chk("pty",      bus.pty,      y);
         chk("pt_last",  bus.pt_last,  (x == xmx && y == ymx) ? 1 : 0);
         chk("fim_scan", bus.fim,      0);
         if (pr) begin
            if (x == xmx) begin
               if (y == ymx) done = 1;
               x = xmn;
               y++;
            end else begin
               x++;
            end
         end
         tick();
         cyc++;
         if (cyc > 3000) begin
            chk("scan_timeout", 1, 0);
            done = 1;
         end
      end
      bus.pt_ready = 1'b0;
      chk("fim_pulse",    bus.fim,       1);
      chk("pt_valid_end", bus.pt_valid,  0);
      chk("tri_ready_f",  bus.tri_ready, 0);
      tick();
      chk("fim_drop",     bus.fim,       0);
      chk("tri_ready_i",  bus.tri_ready, 1);
      chk("ocupado_i",    bus.ocupado,   0);
   endtask

   initial begin
      bus.tri_valid = 1'b0;
      bus.pt_ready  = 1'b0;
      bus.t1x = '0; bus.t1y = '0; bus.t2x = '0; bus.t2y = '0; bus.t3x = '0; bus.t3y = '0;
      rst = 1'b1;
      tick();
      tick();
      chk("rst_tri_ready", bus.tri_ready, 1);
      chk("rst_pt_valid",  bus.pt_valid,  0);
      chk("rst_pt_last",   bus.pt_last,   0);
      chk("rst_fim",       bus.fim,       0);
      chk("rst_ocupado",   bus.ocupado,   0);
      chk("rst_ptx",       bus.ptx,       0);
      chk("rst_pty",       bus.pty,       0);
      chk("rst_p3y",       bus.p3y,       0);
      rst = 1'b0;
      tick();

      // Basic: box 2..5 x 3..6, points in cycles 2-17, fim 18, ready 19
      send_tri(2, 3, 5, 3, 3, 6);
      scan(2, 5, 3, 6, 0);

      // Same triangle under 1-0-0 backpressure
      send_tri(2, 3, 5, 3, 3, 6);
      scan(2, 5, 3, 6, 1);

      // Single point: pt_last in cycle 2, fim in cycle 3
      send_tri(7, 7, 7, 7, 7, 7);
      scan(7, 7, 7, 7, 0);

      // Clipped to x = 630..639, y = 10..12
      send_tri(630, 10, 700, 10, 650, 12);
      scan(630, 639, 10, 12, 0);

      // Empty box: fim in cycle 2, tri_ready in cycle 3
      send_tri(640, 1, 700, 2, 650, 3);
      chk("empty_pt_valid", bus.pt_valid,  0);
      chk("empty_fim",      bus.fim,       1);
      chk("empty_ready_c2", bus.tri_ready, 0);
      tick();
      chk("empty_fim_drop", bus.fim,       0);
      chk("empty_ready_c3", bus.tri_ready, 1);

      // Reset while point 5 (2,4) is presented
      send_tri(2, 3, 5, 3, 3, 6);
      bus.pt_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("mid_ptx", bus.ptx, 2);
      chk("mid_pty", bus.pty, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.pt_ready = 1'b0;
      chk("mrst_pt_valid",  bus.pt_valid,  0);
      chk("mrst_fim",       bus.fim,       0);
      chk("mrst_tri_ready", bus.tri_ready, 1);
      chk("mrst_ocupado",   bus.ocupado,   0);
      chk("mrst_ptx",       bus.ptx,       0);
      chk("mrst_pty",       bus.pty,       0);
      chk("mrst_p1x",       bus.p1x,       0);
      tick();
      chk("mrst_fim2",      bus.fim,       0);

      // Reuse after abort
      send_tri(10, 20, 11, 20, 10, 21);
      scan(10, 11, 20, 21, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
